// File: rtl/ms_timer_sched.sv
// ms_timer_sched: four countdown channels on a shared tick, expiries merged round-robin onto one valid/ready port
module ms_timer_sched #(
  parameter int TICK_DIV = 10000,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    start,
  input  logic [3:0]    cancel,
  input  logic [DW-1:0] dur,
  output logic          tick,
  output logic [3:0]    busy,
  output logic          evt_valid,
  output logic [1:0]    evt_id,
  input  logic          evt_ready,
  output logic [3:0]    overrun
);
  typedef enum logic {IDLE, RUN} ch_t;
  typedef enum logic {A_IDLE, A_HOLD} arb_t;
  logic [15:0]   cnt_q, cnt_d;
  logic          tick_q, tick_d;
  ch_t           st_q [4];
  ch_t           st_d [4];
  logic [DW-1:0] rem_q [4];
  logic [DW-1:0] rem_d [4];
  logic [3:0]    exp_s, pend_q, pend_d, ovr_q, ovr_d, clr;
  arb_t          arb_q, arb_d;
  logic [1:0]    last_q, last_d, id_q, id_d, pick;
  // prescaler wraps at TICK_DIV-1; the tick register fires the cycle after
  always_comb begin
    tick_d = cnt_q == 16'(TICK_DIV - 1);
    cnt_d  = tick_d ? '0 : cnt_q + 16'd1;
  end
  // channel next state: cancel beats start, start beats tick
  always_comb begin
    exp_s = '0;
    for (int i = 0; i < 4; i++) begin
      st_d[i]  = st_q[i];
      rem_d[i] = rem_q[i];
      busy[i]  = st_q[i] == RUN;
      if (cancel[i]) begin
        st_d[i] = IDLE;
      end else if (start[i]) begin
        st_d[i]  = dur != '0 ? RUN : IDLE;
        rem_d[i] = dur != '0 ? dur : rem_q[i];
        exp_s[i] = dur == '0;
      end else if (st_q[i] == RUN && tick_q) begin
        st_d[i]  = rem_q[i] == DW'(1) ? IDLE : RUN;
        rem_d[i] = rem_q[i] - DW'(1);
        exp_s[i] = rem_q[i] == DW'(1);
      end
    end
  end
  // round-robin search starting just after the last granted channel
  always_comb begin
    pick = last_q;
    for (int k = 4; k >= 1; k--)
      if (pend_q[last_q + 2'(k)]) pick = last_q + 2'(k);
  end
  // arbiter grant/handshake and the pending/overrun bookkeeping it drives
  always_comb begin
    arb_d  = arb_q;
    id_d   = id_q;
    last_d = last_q;
    clr    = '0;
    if (arb_q == A_IDLE && |pend_q) begin
      arb_d = A_HOLD;
      id_d  = pick;
    end else if (arb_q == A_HOLD && evt_ready) begin
      arb_d  = A_IDLE;
      last_d = id_q;
      clr    = 4'b0001 << id_q;
    end
    pend_d = (pend_q | exp_s) & ~clr;
    ovr_d  = (ovr_q & ~start) | (exp_s & pend_q);
  end
  // state registers, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      pend_q <= '0;
      ovr_q  <= '0;
      arb_q  <= A_IDLE;
      last_q <= 2'd3;
      id_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        st_q[i]  <= IDLE;
        rem_q[i] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      arb_q  <= arb_d;
      last_q <= last_d;
      id_q   <= id_d;
      for (int i = 0; i < 4; i++) begin
        st_q[i]  <= st_d[i];
        rem_q[i] <= rem_d[i];
      end
    end
  end
  assign tick      = tick_q;
  assign evt_valid = arb_q == A_HOLD;
  assign evt_id    = id_q;
  assign overrun   = ovr_q;
endmodule
